// File: rtl/iter_muldiv_if.sv
// iter_muldiv_if: operand request and register-file writeback bundle for the iterative multiply/divide unit.
interface iter_muldiv_if #(parameter int W = 8, parameter int D = 4);
  logic start;
  logic op;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic [D-1:0] dest_addr;
  logic busy;
  logic done;
  logic reg_write;
  logic [D-1:0] waddr;
  logic [W-1:0] wdata;
  logic div_by_zero;
  modport master(output start, op, operand_a, operand_b, dest_addr,
                 input busy, done, reg_write, waddr, wdata, div_by_zero);
  modport slave(input start, op, operand_a, operand_b, dest_addr,
                output busy, done, reg_write, waddr, wdata, div_by_zero);
endinterface

// File: rtl/iter_muldiv.sv
// iter_muldiv: one-bit-per-cycle shift-add multiply / restoring divide with two-cycle register writeback.
module iter_muldiv #(parameter int W = 8, parameter int D = 4) (
  input logic clk,
  input logic reset,
  iter_muldiv_if.slave bus
);
  localparam int CW = $clog2(W);
  typedef enum logic [1:0] {IDLE, CALC, WB_LO, WB_HI} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic op_q;
  logic [W-1:0] a_q, b_q, hi, lo, hi_nxt, lo_nxt, wdata_q;
  logic [D-1:0] dest_q, waddr_q;
  logic dz_q;
  logic [W:0] sum, shifted, diff;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state == IDLE  ? (bus.start ? CALC : IDLE) :
                state == CALC  ? (cnt == '0 ? WB_LO : CALC) :
                state == WB_LO ? WB_HI : IDLE;
  end
  always_comb begin
    bus.busy = state != IDLE;
    bus.done = state == WB_HI;
    bus.reg_write = state == WB_LO || state == WB_HI;
    bus.waddr = waddr_q;
    bus.wdata = wdata_q;
    bus.div_by_zero = dz_q;
  end
  // hi/lo hold the product halves for multiply and remainder/quotient for divide,
  // so writeback is identical for both ops; a zero divisor naturally yields all-ones / dividend
  always_comb begin
    sum = {1'b0, hi} + {1'b0, lo[0] ? a_q : {W{1'b0}}};
    shifted = {hi, lo[W-1]};
    diff = shifted - {1'b0, b_q};
    hi_nxt = op_q ? (diff[W] ? shifted[W-1:0] : diff[W-1:0]) : sum[W:1];
    lo_nxt = op_q ? {lo[W-2:0], ~diff[W]} : {sum[0], lo[W-1:1]};
  end
  always_ff @(posedge clk)
    if (reset) begin
      cnt <= '0;
      op_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      dest_q <= '0;
      hi <= '0;
      lo <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      dz_q <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      cnt <= CW'(W - 1);
      op_q <= bus.op;
      a_q <= bus.operand_a;
      b_q <= bus.operand_b;
      dest_q <= bus.dest_addr;
      hi <= '0;
      lo <= bus.op ? bus.operand_a : bus.operand_b;
      dz_q <= bus.op && bus.operand_b == '0;
    end else if (state == CALC) begin
      cnt <= cnt - CW'(1);
      hi <= hi_nxt;
      lo <= lo_nxt;
      if (cnt == '0) begin
        waddr_q <= dest_q;
        wdata_q <= lo_nxt;
      end
    end else if (state == WB_LO) begin
      waddr_q <= dest_q + D'(1);
      wdata_q <= hi;
    end
endmodule
